// File: rtl/seg7_scroll_ctrl.sv
// Marquee sequencer for the six-digit HEX display bank: holds a loaded message and
// rewrites all six digits every TICK_DIV cycles, shifting one character left each step.
module seg7_scroll_ctrl #(
    parameter int MSG_DEPTH = 16,
    parameter int AW        = 4,
    parameter int TICK_DIV  = 25000000
) (
    input  logic          Clock,
    input  logic          Resetn,
    input  logic          WrEn,
    input  logic [AW-1:0] WrAddr,
    input  logic [6:0]    WrData,
    input  logic [AW:0]   Len,
    input  logic          Start,
    input  logic          Stop,
    output logic          Busy,
    output logic [AW-1:0] Pos,
    output logic [6:0]    Seg_Data,
    output logic [2:0]    Seg_Addr,
    output logic          Seg_Sel
);

    localparam int              TW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TW-1:0]   TICK_LOAD = TW'(TICK_DIV - 1);
    localparam logic [AW:0]     DEPTH_L   = (AW+1)'(MSG_DEPTH);

    typedef enum logic [1:0] {IDLE, UPDATE, WAIT} state_t;

    state_t          state;
    logic [6:0]      msg_buf [MSG_DEPTH];
    logic [AW-1:0]   last_idx;
    logic [AW-1:0]   rd_idx;
    logic [2:0]      k;
    logic [TW-1:0]   tick;
    logic            stop_pend;
    logic [AW:0]     len_clip;
    logic            start_ok;
    logic [AW-1:0]   pos_next;

    // Circular increment over the active message length; also yields (Pos+k) mod L
    // incrementally, so lengths below six repeat across the digits.
    function automatic logic [AW-1:0] wrap_inc(input logic [AW-1:0] i,
                                               input logic [AW-1:0] last);
        return (i == last) ? '0 : i + 1'b1;
    endfunction

    assign len_clip = (Len > DEPTH_L) ? DEPTH_L : Len;
    assign start_ok = Start && !Stop && (Len != '0);
    assign pos_next = wrap_inc(Pos, last_idx);

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            state     <= IDLE;
            Busy      <= 1'b0;
            Pos       <= '0;
            Seg_Sel   <= 1'b0;
            Seg_Data  <= '0;
            Seg_Addr  <= '0;
            tick      <= '0;
            k         <= '0;
            stop_pend <= 1'b0;
            last_idx  <= '0;
            rd_idx    <= '0;
            for (int i = 0; i < MSG_DEPTH; i++) msg_buf[i] <= '0;
        end else begin
            if (WrEn) msg_buf[WrAddr] <= WrData;

            unique case (state)
                IDLE: begin
                    Seg_Sel   <= 1'b0;
                    stop_pend <= 1'b0;
                    if (start_ok) begin
                        last_idx <= AW'(len_clip - 1'b1);
                        Pos      <= '0;
                        rd_idx   <= '0;
                        k        <= '0;
                        Busy     <= 1'b1;
                        state    <= UPDATE;
                    end
                end
                UPDATE: begin
                    Seg_Sel  <= 1'b1;
                    Seg_Addr <= 3'd5 - k;
                    Seg_Data <= msg_buf[rd_idx];
                    rd_idx   <= wrap_inc(rd_idx, last_idx);
                    k        <= k + 3'd1;
                    // A Stop during the burst only takes effect once HEX0 is written.
                    if (k == 3'd5) begin
                        if (stop_pend || Stop) begin
                            state     <= IDLE;
                            Busy      <= 1'b0;
                            stop_pend <= 1'b0;
                        end else begin
                            tick  <= TICK_LOAD;
                            state <= WAIT;
                        end
                    end else if (Stop) begin
                        stop_pend <= 1'b1;
                    end
                end
                WAIT: begin
                    Seg_Sel <= 1'b0;
                    if (Stop) begin
                        state <= IDLE;
                        Busy  <= 1'b0;
                    end else if (tick == '0) begin
                        Pos    <= pos_next;
                        rd_idx <= pos_next;
                        k      <= '0;
                        state  <= UPDATE;
                    end else begin
                        tick <= tick - 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    Busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seg7_scroll_ctrl.sv
// Bench for seg7_scroll_ctrl: directed scenarios plus random traffic, every cycle
// checked against a phase-arithmetic model of the scroll sequence.
module tb_seg7_scroll_ctrl;

    localparam int MSG_DEPTH = 16;
    localparam int AW        = 4;
    localparam int TICK_DIV  = 4;
    localparam int P         = TICK_DIV + 6;

    logic          Clock = 1'b0;
    logic          Resetn;
    logic          WrEn;
    logic [AW-1:0] WrAddr;
    logic [6:0]    WrData;
    logic [AW:0]   Len;
    logic          Start;
    logic          Stop;
    logic          Busy;
    logic [AW-1:0] Pos;
    logic [6:0]    Seg_Data;
    logic [2:0]    Seg_Addr;
    logic          Seg_Sel;

    seg7_scroll_ctrl #(.MSG_DEPTH(MSG_DEPTH), .AW(AW), .TICK_DIV(TICK_DIV)) dut (
        .Clock(Clock), .Resetn(Resetn), .WrEn(WrEn), .WrAddr(WrAddr), .WrData(WrData),
        .Len(Len), .Start(Start), .Stop(Stop), .Busy(Busy), .Pos(Pos),
        .Seg_Data(Seg_Data), .Seg_Addr(Seg_Addr), .Seg_Sel(Seg_Sel)
    );

    always #5 Clock = ~Clock;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: edges since the accepted Start give burst number and phase.
    int mbuf [MSG_DEPTH];
    bit m_run, m_stopreq;
    int m_j, m_L, m_pos, m_sel, m_addr, m_data;

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        int p, b;
        @(posedge Clock);
        if (!Resetn) begin
            m_run = 0; m_stopreq = 0; m_pos = 0; m_sel = 0; m_addr = 0; m_data = 0;
            for (int i = 0; i < MSG_DEPTH; i++) mbuf[i] = 0;
        end else begin
            if (!m_run) begin
                m_sel = 0;
                if (Start && !Stop && Len != 0) begin
                    m_run = 1; m_j = 0; m_pos = 0; m_stopreq = 0;
                    m_L = (int'(Len) > MSG_DEPTH) ? MSG_DEPTH : int'(Len);
                end
            end else begin
                m_j++;
                p = (m_j - 1) % P;
                b = (m_j - 1) / P;
                if (p < 6) begin
                    m_sel  = 1;
                    m_addr = 5 - p;
                    m_data = mbuf[((b % m_L) + p) % m_L];
                    m_pos  = b % m_L;
                    if (Stop) m_stopreq = 1;
                    if (p == 5 && m_stopreq) m_run = 0;
                end else begin
                    m_sel = 0;
                    if (Stop) begin
                        m_run = 0;
                        m_pos = b % m_L;
                    end else begin
                        m_pos = (p == P - 1) ? (b + 1) % m_L : b % m_L;
                    end
                end
            end
            if (WrEn) mbuf[WrAddr] = int'(WrData);
        end
        #1;
        chk("busy", int'(Busy), int'(m_run));
        chk("pos", int'(Pos), m_pos);
        chk("seg_sel", int'(Seg_Sel), m_sel);
        chk("seg_addr", int'(Seg_Addr), m_addr);
        chk("seg_data", int'(Seg_Data), m_data);
    endtask

    task automatic idle_in();
        WrEn = 0; Start = 0; Stop = 0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic write(input int a, input int d);
        WrEn = 1; WrAddr = AW'(a); WrData = 7'(d);
        step();
        WrEn = 0;
    endtask

    task automatic do_start(input int l);
        Len = (AW+1)'(l); Start = 1;
        step();
        Start = 0;
    endtask

    task automatic stop_pulse();
        Stop = 1;
        step();
        Stop = 0;
    endtask

    initial begin
        Resetn = 0; WrAddr = '0; WrData = '0; Len = '0;
        idle_in();
        run(2);
        Resetn = 1;
        run(1);

        // Eight-character message: first bursts, scroll through Pos=7 and the wrap to 0.
        for (int i = 0; i < 8; i++) write(i, i + 1);
        do_start(8);
        run(P * 9 + 2);
        stop_pulse();
        run(3);

        // Short message repeats across the digits.
        write(0, 'h11); write(1, 'h22); write(2, 'h33);
        do_start(3);
        run(P * 3);
        stop_pulse();
        run(8);

        // Len=0 and Start+Stop together are both ignored.
        do_start(0);
        run(4);
        Len = 8; Start = 1; Stop = 1;
        step();
        Start = 0; Stop = 0;
        run(4);

        // Stop on the third strobe, then Stop while waiting.
        for (int i = 0; i < 8; i++) write(i, i + 1);
        do_start(8);
        run(2);
        stop_pulse();
        run(10);
        do_start(8);
        run(P + 7);
        stop_pulse();
        run(5);

        // Buffer write while waiting shows up in the next burst.
        do_start(8);
        run(7);
        write(1, 'h7F);
        run(P * 2);
        stop_pulse();
        run(8);

        // Reset mid-burst clears everything including the buffer.
        do_start(8);
        run(2);
        Resetn = 0;
        step();
        Resetn = 1;
        run(2);
        do_start(8);
        run(P + 4);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            WrEn   = ($urandom_range(0, 99) < 30);
            WrAddr = AW'($urandom_range(0, MSG_DEPTH - 1));
            WrData = 7'($urandom_range(0, 127));
            Len    = (AW+1)'($urandom_range(0, 31));
            Start  = ($urandom_range(0, 99) < 6);
            Stop   = ($urandom_range(0, 99) < 2);
            Resetn = ($urandom_range(0, 999) >= 5);
            step();
        end
        Resetn = 1;
        idle_in();
        run(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
